// File: rtl/csa_5_2_array_pipe.sv
// Row of W 5:2 carry-save compressor slices with optional carry-save accumulate
// feedback and a STAGES-deep valid/ready output pipeline. No carry-propagate add.
module csa_5_2_array_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         acc_en,
  input  logic         acc_clr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  input  logic         cin1,
  input  logic         cin2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o,
  output logic         cout1_o,
  output logic         cout2_o
);

  localparam int DW = 2*W + 2;

  logic [W-1:0] acc_s_q, acc_s_d;
  // acc_c[W-1] would be shifted out of the e operand, so it is never stored
  logic [W-2:0] acc_c_q, acc_c_d;

  logic [W-1:0] op_d, op_e;
  logic [W-1:0] fa1_s, fa2_s, row_sum, row_carry;
  logic [W:0]   c1, c2;
  logic         in_fire;

  logic [STAGES-1:0] v_q, v_d, ld;
  logic [DW-1:0]     stg_q [STAGES];
  logic [DW-1:0]     stg_d [STAGES];

  always_comb begin
    op_d = d;
    op_e = e;
    if (acc_en) begin
      op_d = acc_clr ? '0 : acc_s_q;
      op_e = acc_clr ? '0 : {acc_c_q, 1'b0};
    end
  end

  // cout1 of a slice depends only on a/b/c, so the row has no ripple path
  always_comb begin
    fa1_s     = a ^ b ^ c;
    c1        = {(a & b) | (a & c) | (b & c), cin1};
    fa2_s     = fa1_s ^ op_d ^ c1[W-1:0];
    c2        = {(fa1_s & op_d) | (fa1_s & c1[W-1:0]) | (op_d & c1[W-1:0]), cin2};
    row_sum   = fa2_s ^ op_e ^ c2[W-1:0];
    row_carry = (fa2_s & op_e) | (fa2_s & c2[W-1:0]) | (op_e & c2[W-1:0]);
  end

  always_comb begin
    ld = '0;
    ld[STAGES-1] = !v_q[STAGES-1] | out_ready;
    for (int i = STAGES-2; i >= 0; i--) begin
      ld[i] = !v_q[i] | ld[i+1];
    end
  end

  assign in_ready = ld[0];
  assign in_fire  = in_valid & ld[0];

  always_comb begin
    acc_s_d = acc_s_q;
    acc_c_d = acc_c_q;
    if (in_fire && acc_en) begin
      acc_s_d = row_sum;
      acc_c_d = row_carry[W-2:0];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < STAGES; i++) begin
      stg_d[i] = stg_q[i];
    end
    if (ld[0]) begin
      v_d[0]   = in_fire;
      stg_d[0] = {row_carry, row_sum, c1[W], c2[W]};
    end
    for (int i = 1; i < STAGES; i++) begin
      if (ld[i]) begin
        v_d[i]   = v_q[i-1];
        stg_d[i] = stg_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s_q <= '0;
      acc_c_q <= '0;
      v_q     <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      acc_s_q <= acc_s_d;
      acc_c_q <= acc_c_d;
      v_q     <= v_d;
      for (int i = 0; i < STAGES; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign {carry_o, sum_o, cout1_o, cout2_o} = stg_q[STAGES-1];

endmodule

// File: tb/tb_csa_5_2_array_pipe.sv
// Directed and randomised checks of csa_5_2_array_pipe (W=16, STAGES=2) against
// the arithmetic identity sum + 2*carry + 2^16*(cout1+cout2).
module tb_csa_5_2_array_pipe;

  localparam int W      = 16;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         acc_en = 1'b0;
  logic         acc_clr = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0, e = '0;
  logic         cin1 = 1'b0, cin2 = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum_o, carry_o;
  logic         cout1_o, cout2_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  int unsigned accv     = 0;
  int unsigned exp_q [$];
  bit          mod_q [$];

  csa_5_2_array_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b), .c(c), .d(d), .e(e),
    .cin1(cin1), .cin2(cin2), .out_valid(out_valid), .out_ready(out_ready),
    .sum_o(sum_o), .carry_o(carry_o), .cout1_o(cout1_o), .cout2_o(cout2_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned tot();
    return 32'(sum_o) + 2 * 32'(carry_o) + 32'h10000 * (32'(cout1_o) + 32'(cout2_o));
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_beat(input bit v, input bit ae, input bit ac,
                          input logic [W-1:0] ia, ib, ic, id, ie,
                          input bit ci1, ci2);
    in_valid = v; acc_en = ae; acc_clr = ac;
    a = ia; b = ib; c = ic; d = id; e = ie;
    cin1 = ci1; cin2 = ci2;
  endtask

  // One clock: log an accepted beat into the reference queue, check any result taken.
  task automatic cycle_sb(output bit fired);
    int unsigned ev;
    int unsigned base;
    bit          m;
    #1;
    fired = in_valid && in_ready;
    if (fired) begin
      if (acc_en) begin
        base = acc_clr ? 0 : accv;
        ev   = (32'(a) + 32'(b) + 32'(c) + base + 32'(cin1) + 32'(cin2)) & 32'hFFFF;
        accv = ev;
        m    = 1'b1;
      end else begin
        ev = 32'(a) + 32'(b) + 32'(c) + 32'(d) + 32'(e) + 32'(cin1) + 32'(cin2);
        m  = 1'b0;
      end
      exp_q.push_back(ev);
      mod_q.push_back(m);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        ev = exp_q.pop_front();
        m  = mod_q.pop_front();
        chk("sb_out", m ? (tot() & 32'hFFFF) : tot(), ev);
      end
    end
    tick();
  endtask

  task automatic send(input bit ae, input bit ac, input logic [W-1:0] ia, ib, ic, id, ie,
                      input bit ci1, ci2);
    bit f;
    int k;
    set_beat(1'b1, ae, ac, ia, ib, ic, id, ie, ci1, ci2);
    k = 0;
    f = 1'b0;
    while (!f && k < 20) begin
      cycle_sb(f);
      k++;
    end
    if (!f) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    bit f;
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < maxc) begin
      cycle_sb(f);
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit f;
    int n0;
    logic [W-1:0] av [4];
    int bi;
    int k;

    // reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum_o, 0);
    chk("rst_carry", carry_o, 0);
    chk("rst_couts", {cout1_o, cout2_o}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // all-ones beat, two-edge latency
    set_beat(1, 0, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1);
    tick();
    in_valid = 1'b0;
    chk("ones_lat1_valid", out_valid, 0);
    tick();
    chk("ones_lat2_valid", out_valid, 1);
    chk("ones_value", tot(), 327677);
    tick();
    chk("ones_gone", out_valid, 0);

    // back-to-back accumulate; d/e must be ignored
    set_beat(1, 1, 1, 16'd3, 0, 0, 16'h1234, 16'h4321, 0, 0);
    tick();
    chk("acc_lat1_valid", out_valid, 0);
    set_beat(1, 1, 0, 16'd5, 0, 0, 16'h1234, 16'h4321, 0, 0);
    tick();
    chk("acc1_valid", out_valid, 1);
    chk("acc1_value", tot() & 32'hFFFF, 3);
    set_beat(1, 1, 0, 16'd7, 0, 0, 16'h1234, 16'h4321, 0, 0);
    tick();
    chk("acc2_value", tot() & 32'hFFFF, 8);
    in_valid = 1'b0;
    tick();
    chk("acc3_valid", out_valid, 1);
    chk("acc3_value", tot() & 32'hFFFF, 15);
    tick();
    chk("acc_done", out_valid, 0);
    accv = 15;

    // backpressure: fill, stall, then release
    av[0] = 16'd10; av[1] = 16'd20; av[2] = 16'd30; av[3] = 16'd40;
    n0 = n_out;
    out_ready = 1'b0;
    set_beat(1, 0, 0, av[0], 0, 0, 0, 0, 0, 0);
    cycle_sb(f);
    chk("bp_accept_a", f, 1);
    set_beat(1, 0, 0, av[1], 0, 0, 0, 0, 0, 0);
    cycle_sb(f);
    chk("bp_accept_b", f, 1);
    set_beat(1, 0, 0, av[2], 0, 0, 0, 0, 0, 0);
    cycle_sb(f);
    chk("bp_full_reject", f, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_value", tot(), 10);
      chk("bp_in_ready_low", in_ready, 0);
      cycle_sb(f);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_no_lost_slot", in_ready, 1);
    bi = 2;
    k = 0;
    while (bi < 4 && k < 20) begin
      set_beat(1, 0, 0, av[bi], 0, 0, 0, 0, 0, 0);
      cycle_sb(f);
      if (f) bi++;
      k++;
    end
    chk("bp_all_sent", bi, 4);
    drain(20);
    chk("bp_out_count", n_out - n0, 4);

    // wrap mod 2^16, then a non-acc beat that must not touch the accumulator
    send(1, 1, 16'h8000, 0, 0, 0, 0, 0, 0);
    send(1, 0, 16'h8000, 0, 0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 16'd1, 16'd1, 0, 0);
    send(1, 0, 16'd1, 0, 0, 16'h00FF, 16'h00FF, 0, 0);
    drain(20);

    // reset with two beats in flight
    send(0, 0, 16'd100, 0, 0, 0, 0, 0, 0);
    send(0, 0, 16'd200, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_value", tot(), 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    mod_q.delete();
    accv = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 0);
    send(1, 0, 16'd1, 0, 0, 16'h0055, 16'h0055, 0, 0);
    tick();
    chk("post_rst_acc_value", tot() & 32'hFFFF, 1);
    drain(20);

    // random handshakes and modes
    for (int i = 0; i < 2000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        set_beat(1, $urandom_range(0, 1), 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1);
      else
        set_beat($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 1));
      cycle_sb(f);
    end
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
